// File: rtl/psram_wb_rdbuf_pkg.sv
// psram_wb_rdbuf_pkg
//   Shared types and helpers for the PSRAM Wishbone read buffer.
//   - state_t     : controller FSM states
//   - index_w()   : line-index width for a given line count
//   - tag_w()     : tag width for a given line count and PSRAM address width
//   - byte_merge(): lane-wise merge of a new word into an old word
package psram_wb_rdbuf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        ACK     = 2'd3
    } state_t;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Lines hold one 32-bit word each, so byte-offset bits [1:0] are not part of the tag.
    function automatic int tag_w(input int lines, input int addr_w);
        return addr_w - $clog2(lines) - 2;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/psram_rdbuf_array.sv
// psram_rdbuf_array
//   Valid/tag/data storage for the direct-mapped one-word-per-line buffer.
//   Ports:
//     clk, rst          clock, async active-high reset (clears valid bits only)
//     flush             invalidate every line; overrides a same-edge fill
//     index, tag        line select and tag for lookup and for both update ports
//     hit, rdata        combinational lookup result for index/tag
//     fill, fill_data   allocate the line: set valid, store tag and data
//     merge, merge_data, merge_sel
//                       byte-lane update of the line data (caller gates on hit)
module psram_rdbuf_array
    import psram_wb_rdbuf_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 24,
    localparam int INDEX_W = index_w(LINES),
    localparam int TAG_W   = tag_w(LINES, ADDR_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output logic [31:0]        rdata,
    input  logic               fill,
    input  logic [31:0]        fill_data,
    input  logic               merge,
    input  logic [31:0]        merge_data,
    input  logic [3:0]         merge_sel
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    assign hit   = valid[index] && (tags[index] == tag);
    assign rdata = data[index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[index] <= tag;
            data[index] <= fill_data;
        end else if (merge) begin
            data[index] <= byte_merge(data[index], merge_data, merge_sel);
        end
    end

endmodule

// File: rtl/psram_wb_rdbuf.sv
// psram_wb_rdbuf
//   Direct-mapped write-through word buffer between the SoC Wishbone master
//   and the slow PSRAM QSPI Wishbone controller. Read hits ack one cycle after
//   the request; misses fetch a full word; writes always go downstream and only
//   update a line that already holds the address (no write allocate).
//   Ports:
//     clk_i, rst_i      clock, async active-high reset
//     flush_i           single-cycle pulse, invalidates all lines
//     s_*               upstream Wishbone slave side (s_ack_o is a 1-cycle pulse)
//     m_*               downstream Wishbone master side, all outputs registered
module psram_wb_rdbuf
    import psram_wb_rdbuf_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic [3:0]  s_sel_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    output logic        s_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic        m_ack_i
);

    localparam int INDEX_W = index_w(LINES);
    localparam int TAG_W   = tag_w(LINES, ADDR_W);

    state_t state, state_next;

    logic [ADDR_W-1:2]  req_adr;
    logic [31:0]        req_dat;
    logic [3:0]         req_sel;

    logic               req;
    logic [ADDR_W-1:2]  look_adr;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [31:0]        rdata;
    logic               fill;
    logic               merge;

    assign req = s_cyc_i & s_stb_i;

    // In IDLE the live bus address is looked up so a hit can ack next cycle;
    // afterwards the latched request address selects the line for fill/merge.
    assign look_adr = (state == IDLE) ? s_adr_i[ADDR_W-1:2] : req_adr;
    assign index    = look_adr[INDEX_W+1:2];
    assign tag      = look_adr[ADDR_W-1:INDEX_W+2];

    assign fill  = (state == RD_MISS) && m_ack_i;
    assign merge = (state == WR_THRU) && m_ack_i && hit;

    psram_rdbuf_array #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (flush_i),
        .index      (index),
        .tag        (tag),
        .hit        (hit),
        .rdata      (rdata),
        .fill       (fill),
        .fill_data  (m_dat_i),
        .merge      (merge),
        .merge_data (req_dat),
        .merge_sel  (req_sel)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (s_we_i)   state_next = WR_THRU;
                    else if (hit) state_next = ACK;
                    else          state_next = RD_MISS;
                end
            end
            RD_MISS: if (m_ack_i) state_next = ACK;
            WR_THRU: if (m_ack_i) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign s_ack_o = (state == ACK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_adr <= '0;
            req_dat <= '0;
            req_sel <= '0;
            s_dat_o <= '0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_sel_o <= '0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        req_adr <= s_adr_i[ADDR_W-1:2];
                        req_dat <= s_dat_i;
                        req_sel <= s_sel_i;
                        if (s_we_i) begin
                            m_adr_o <= s_adr_i;
                            m_dat_o <= s_dat_i;
                            m_sel_o <= s_sel_i;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= 1'b1;
                        end else if (hit) begin
                            s_dat_o <= rdata;
                        end else begin
                            m_adr_o <= {s_adr_i[31:2], 2'b00};
                            m_sel_o <= 4'hF;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= 1'b0;
                        end
                    end
                end
                RD_MISS: begin
                    if (m_ack_i) begin
                        s_dat_o <= m_dat_i;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        m_we_o  <= 1'b0;
                    end
                end
                WR_THRU: begin
                    if (m_ack_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        m_we_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_wb_rdbuf.sv
// tb_psram_wb_rdbuf
//   Directed and randomized bench for psram_wb_rdbuf (LINES=16, ADDR_W=24).
//   A behavioural PSRAM stub answers downstream cycles after a programmable
//   latency. Expected read data comes from a reference memory updated from the
//   upstream writes; expected hit/miss comes from a per-line record of which
//   word address each line currently holds.
module tb_psram_wb_rdbuf;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] s_adr_i;
    logic [31:0] s_dat_i;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_i;
    logic        s_cyc_i;
    logic        s_stb_i;
    logic        s_we_i;
    logic        s_ack_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic        m_ack_i;

    psram_wb_rdbuf #(.LINES(16), .ADDR_W(24)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .s_adr_i (s_adr_i),
        .s_dat_i (s_dat_i),
        .s_dat_o (s_dat_o),
        .s_sel_i (s_sel_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_we_i  (s_we_i),
        .s_ack_o (s_ack_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_dat_i (m_dat_i),
        .m_sel_o (m_sel_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_ack_i (m_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // PSRAM stub state
    int          ds_lat   = 4;
    int          ds_count = 0;
    logic [31:0] ds_adr;
    logic [31:0] ds_dat;
    logic [3:0]  ds_sel;
    logic        ds_we;
    logic [31:0] psram [1024];

    // reference model
    logic [31:0] ref_mem [1024];
    bit          mv [16];
    logic [21:0] mt [16];
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ack"}, 32'(s_ack_o), 32'h0);
        check({tag, "_s_dat"}, s_dat_o, 32'h0);
        check({tag, "_m_adr"}, m_adr_o, 32'h0);
        check({tag, "_m_dat"}, m_dat_o, 32'h0);
        check({tag, "_m_ctl"}, {25'h0, m_cyc_o, m_stb_o, m_we_o, m_sel_o}, 32'h0);
    endtask

    task automatic invalidate_all();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    // Stub: answers one downstream cycle at a time, ack asserted ds_lat cycles
    // after the cycle is first seen; aborts silently if reset arrives.
    initial begin
        bit aborted;
        m_ack_i = 1'b0;
        m_dat_i = 32'h0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && m_cyc_o && m_stb_o) begin
                ds_count++;
                ds_adr  = m_adr_o;
                ds_dat  = m_dat_o;
                ds_sel  = m_sel_o;
                ds_we   = m_we_o;
                aborted = 1'b0;
                for (int w = 1; w < ds_lat; w++) begin
                    @(negedge clk_i);
                    if (rst_i) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("m_adr_stable", m_adr_o, ds_adr);
                    check("m_ctl_stable", {25'h0, m_cyc_o, m_stb_o, m_we_o, m_sel_o},
                          {25'h0, 2'b11, ds_we, ds_sel});
                end
                if (!aborted) begin
                    m_dat_i = ds_we ? $urandom : psram[ds_adr[11:2]];
                    m_ack_i = 1'b1;
                    @(negedge clk_i);
                    m_ack_i = 1'b0;
                    m_dat_i = $urandom;
                    if (ds_we) begin
                        for (int b = 0; b < 4; b++)
                            if (ds_sel[b]) psram[ds_adr[11:2]][8*b +: 8] = ds_dat[8*b +: 8];
                    end
                end
            end
        end
    end

    // One upstream transaction, started on a negedge. flush_at >= 0 pulses
    // flush_i on the negedge that many cycles after the request was driven
    // (0 = same edge the request is sampled); it is clamped to the edge at
    // which the transaction completes its cache update.
    task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int lat, input int flush_at,
                       input string tag);
        int          idx;
        bit          hit;
        int          exp_k;
        int          edge_k;
        int          k;
        int          c0;
        bit          seen;
        logic [31:0] exp_d;
        logic [31:0] exp_adr;

        idx    = int'(adr[5:2]);
        hit    = !we && mv[idx] && (mt[idx] == adr[23:2]);
        exp_k  = hit ? 1 : lat + 1;
        edge_k = exp_k - 1;
        if (flush_at > edge_k) flush_at = edge_k;

        ds_lat  = lat;
        c0      = ds_count;
        s_adr_i = adr;
        s_dat_i = dat;
        s_sel_i = sel;
        s_we_i  = we;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;

        seen = 1'b0;
        k    = 0;
        while (k < 300) begin
            flush_i = (k == flush_at);
            if (k > 0 && s_ack_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_i);
            k++;
        end
        flush_i = 1'b0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;

        check({tag, "_ack_seen"}, 32'(seen), 32'h1);
        check({tag, "_latency"}, 32'(k), 32'(exp_k));
        check({tag, "_ds_count"}, 32'(ds_count - c0), hit ? 32'h0 : 32'h1);
        if (!hit) begin
            exp_adr = we ? adr : {adr[31:2], 2'b00};
            check({tag, "_m_adr"}, ds_adr, exp_adr);
            check({tag, "_m_sel"}, 32'(ds_sel), we ? 32'(sel) : 32'hF);
            check({tag, "_m_we"}, 32'(ds_we), 32'(we));
            if (we) check({tag, "_m_dat"}, ds_dat, dat);
        end
        exp_d = we ? last_rd : ref_mem[adr[11:2]];
        check({tag, "_s_dat"}, s_dat_o, exp_d);

        @(negedge clk_i);
        check({tag, "_ack_pulse"}, 32'(s_ack_o), 32'h0);

        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[11:2]][8*b +: 8] = dat[8*b +: 8];
            if (flush_at >= 0) invalidate_all();
        end else begin
            last_rd = exp_d;
            if (hit) begin
                if (flush_at == 0) invalidate_all();
            end else begin
                if (flush_at >= 0 && flush_at < lat) invalidate_all();
                mv[idx] = 1'b1;
                mt[idx] = adr[23:2];
                if (flush_at == lat) invalidate_all();
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] radr;
        int          fsel;

        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            psram[i]   = v;
            ref_mem[i] = v;
        end
        psram[32'h100 >> 2]   = 32'hDEADBEEF;
        ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        psram[32'h200 >> 2]   = 32'h11223344;
        ref_mem[32'h200 >> 2] = 32'h11223344;
        invalidate_all();
        last_rd = 32'h0;

        rst_i   = 1'b1;
        flush_i = 1'b0;
        s_adr_i = 32'h0;
        s_dat_i = 32'h0;
        s_sel_i = 4'h0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // cold miss then hit, including ignored address bits above ADDR_W
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 20, -1, "cold_rd");
        check("cold_rd_data", s_dat_o, 32'hDEADBEEF);
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, -1, "repeat_rd");
        txn(1'b0, 32'hAB00_0100, 32'h0, 4'h0, 3, -1, "upper_bits_rd");

        // write hit merges into the line
        txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 5, -1, "rd_200");
        txn(1'b1, 32'h0000_0200, 32'h0000_AA00, 4'b0010, 7, -1, "wr_hit");
        txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 5, -1, "rd_200_merged");
        check("merged_data", s_dat_o, 32'h1122_AA44);

        // write miss does not allocate
        txn(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 3, -1, "wr_miss");
        txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 4, -1, "rd_300");

        // alias on index 0
        txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, 2, -1, "alias_a");
        txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 2, -1, "alias_b");
        txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, 2, -1, "alias_a_again");

        // idle flush between two reads
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, -1, "fl_rd1");
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        invalidate_all();
        @(negedge clk_i);
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, -1, "fl_rd2");

        // flush on the fill edge, flush early in the miss, flush with an IDLE hit
        txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 6, 6, "fl_fill_edge");
        txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3, -1, "fl_fill_edge_rd");
        txn(1'b0, 32'h0000_0108, 32'h0, 4'h0, 6, 2, "fl_early");
        txn(1'b0, 32'h0000_0108, 32'h0, 4'h0, 3, -1, "fl_early_rd");
        txn(1'b0, 32'h0000_0108, 32'h0, 4'h0, 3, 0, "fl_same_edge");
        txn(1'b0, 32'h0000_0108, 32'h0, 4'h0, 3, -1, "fl_same_edge_rd");

        // flush coinciding with a write-hit merge
        txn(1'b0, 32'h0000_010C, 32'h0, 4'h0, 2, -1, "fl_wr_rd");
        txn(1'b1, 32'h0000_010C, 32'h5566_7788, 4'b1001, 5, 5, "fl_wr_merge");
        txn(1'b0, 32'h0000_010C, 32'h0, 4'h0, 2, -1, "fl_wr_rd_after");

        // async reset in the middle of a read miss
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 4, -1, "pre_rst_rd");
        ds_lat  = 20;
        s_adr_i = 32'h0000_0144;
        s_we_i  = 1'b0;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("mid_miss_m_cyc", 32'(m_cyc_o), 32'h1);
        #2 rst_i = 1'b1;
        #1 check_zero("async_rst");
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        invalidate_all();
        last_rd = 32'h0;
        @(negedge clk_i);
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, -1, "post_rst_rd");

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            radr = {8'($urandom), 16'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            fsel = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
            txn(1'($urandom_range(0, 2) == 0), radr, $urandom, 4'($urandom),
                int'($urandom_range(1, 6)), fsel, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
